// File: rtl/sdpram_burst_reader.sv
// Burst read engine for a single-clock simple dual-port RAM with 2-cycle read latency.
// Issues RAM reads under a credit limit and streams the words out through a small output FIFO.
module sdpram_burst_reader #(
  parameter int DWIDTH     = 18,
  parameter int AWIDTH     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [AWIDTH:0]   cmd_len,
  output logic              ram_en,
  output logic [AWIDTH-1:0] ram_addr,
  input  logic [DWIDTH-1:0] ram_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_r;
  logic                cmd_ready_r;
  logic                ram_en_r;
  logic [AWIDTH-1:0]   ram_addr_r;
  logic                en_last_r;
  logic [AWIDTH-1:0]   addr_r;
  logic [AWIDTH:0]     rem_r;
  logic                busy_r;
  logic                done_r;

  logic                v1_r;
  logic                v1_last_r;
  logic                v2_r;
  logic                v2_last_r;

  logic [DWIDTH-1:0]   data_mem_r [FIFO_DEPTH];
  logic                last_mem_r [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic                out_valid_r;
  logic [DWIDTH-1:0]   out_data_r;
  logic                out_last_r;

  logic                push_s;
  logic                pop_s;
  logic [CW-1:0]       count_next_s;
  logic [1:0]          inflight_s;
  logic [CW:0]         occupancy_s;
  logic                credit_s;
  logic [PW-1:0]       rd_ptr_next_s;
  logic                bypass_s;
  logic [DWIDTH-1:0]   head_data_s;
  logic                head_last_s;

  assign push_s        = v2_r;
  assign pop_s         = out_valid_r & out_ready;
  assign count_next_s  = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
  // Reads issued but not yet landed in the FIFO after the coming edge.
  assign inflight_s    = {1'b0, ram_en_r} + {1'b0, v1_r};
  assign occupancy_s   = {1'b0, count_next_s} + {{(CW-1){1'b0}}, inflight_s};
  assign credit_s      = occupancy_s < (CW+1)'(FIFO_DEPTH);
  assign rd_ptr_next_s = rd_ptr_r + {{(PW-1){1'b0}}, pop_s};
  // The arriving word becomes the head directly when the FIFO is empty after this pop.
  assign bypass_s      = push_s && (count_r == {{(CW-1){1'b0}}, pop_s});
  assign head_data_s   = bypass_s ? ram_rd_data : data_mem_r[rd_ptr_next_s];
  assign head_last_s   = bypass_s ? v2_last_r   : last_mem_r[rd_ptr_next_s];

  assign cmd_ready = cmd_ready_r;
  assign ram_en    = ram_en_r;
  assign ram_addr  = ram_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;

  // Command FSM and RAM read issue under the credit limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b1;
      ram_en_r    <= 1'b0;
      ram_addr_r  <= '0;
      en_last_r   <= 1'b0;
      addr_r      <= '0;
      rem_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      ram_en_r  <= 1'b0;
      en_last_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              done_r <= 1'b1;
            end else begin
              // Pipeline and FIFO are empty here, so the first read goes out immediately.
              ram_en_r    <= 1'b1;
              ram_addr_r  <= cmd_addr;
              en_last_r   <= (cmd_len == (AWIDTH+1)'(1));
              addr_r      <= cmd_addr + AWIDTH'(1);
              rem_r       <= cmd_len - (AWIDTH+1)'(1);
              cmd_ready_r <= 1'b0;
              busy_r      <= 1'b1;
              state_r     <= (cmd_len == (AWIDTH+1)'(1)) ? DRAIN : RUN;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (credit_s) begin
            ram_en_r   <= 1'b1;
            ram_addr_r <= addr_r;
            en_last_r  <= (rem_r == (AWIDTH+1)'(1));
            addr_r     <= addr_r + AWIDTH'(1);
            rem_r      <= rem_r - (AWIDTH+1)'(1);
            state_r    <= (rem_r == (AWIDTH+1)'(1)) ? DRAIN : RUN;
          end else begin
            state_r <= RUN;
          end
        end
        DRAIN: begin
          if (pop_s && out_last_r) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Read-latency tag pipeline, output FIFO storage and registered head word.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r        <= 1'b0;
      v1_last_r   <= 1'b0;
      v2_r        <= 1'b0;
      v2_last_r   <= 1'b0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else begin
      v1_r      <= ram_en_r;
      v1_last_r <= en_last_r;
      v2_r      <= v1_r;
      v2_last_r <= v1_last_r;
      if (push_s) begin
        data_mem_r[wr_ptr_r] <= ram_rd_data;
        last_mem_r[wr_ptr_r] <= v2_last_r;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != '0);
      if (count_next_s != '0) begin
        out_data_r <= head_data_s;
        out_last_r <= head_last_s;
      end else begin
        out_data_r <= '0;
        out_last_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdpram_burst_reader.sv
// Self-checking bench: behavioural 2-cycle-latency RAM, directed scenarios plus random bursts,
// with a queue-based reference of expected addresses and words.
module tb_sdpram_burst_reader;

  localparam int DW = 18;
  localparam int AW = 10;
  localparam int FD = 4;
  localparam int NW = 1 << AW;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  sdpram_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address registered at the edge after en, dout updated one edge later, stale otherwise.
  logic [DW-1:0] ram [0:NW-1];
  logic [AW-1:0] ram_a_q;
  logic          ram_en_q;
  initial ram_rd_data = '0;
  always @(posedge clk) begin
    ram_en_q <= ram_en;
    if (ram_en) ram_a_q <= ram_addr;
    if (ram_en_q) ram_rd_data <= ram[ram_a_q];
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit last_acc = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: a burst yields addresses (addr+i) mod 2**AW and the RAM word at each, last on the final one.
  task automatic model_accept(input logic [AW-1:0] a, input logic [AW:0] l);
    exp_t e;
    int   ad;
    for (int i = 0; i < int'(l); i++) begin
      ad = (int'(a) + i) % NW;
      addr_q.push_back(AW'(ad));
      e.data = ram[ad];
      e.last = (i == int'(l) - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock: observe at the falling edge, then advance past the next rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    last_acc = (cmd_valid === 1'b1 && cmd_ready === 1'b1);
    if (last_acc) model_accept(cmd_addr, cmd_len);
    if (ram_en === 1'b1) begin
      if (addr_q.size() == 0) chk("ram_en_unexpected", 32'd1, 32'd0);
      else chk("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(prev_data));
      chk("stall_last", 32'(out_last), 32'(prev_last));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("word_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.data));
        chk("out_last", 32'(out_last), 32'(e.last));
      end
    end
    prev_stall = (out_valid === 1'b1 && out_ready !== 1'b1);
    prev_data  = out_data;
    prev_last  = out_last;
    if (done === 1'b1) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    exp_q.delete();
    addr_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic set_ready(input int mode, input int n);
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (n >= 10 && n < 30) ? 1'b0 : (n % 3 == 0);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run_burst(input logic [AW-1:0] a, input logic [AW:0] l, input int mode, input int budget);
    int d0;
    int n;
    bit got;
    d0 = done_cnt;
    n = 0;
    got = 1'b0;
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1'b1;
    while (!got && n < budget) begin
      set_ready(mode, n);
      cycle();
      got = last_acc;
      n++;
    end
    cmd_valid = 1'b0;
    if (!got) chk("cmd_accept_timeout", 32'd0, 32'd1);
    while (done_cnt == d0 && n < budget) begin
      set_ready(mode, n);
      cycle();
      n++;
    end
    out_ready = 1'b1;
    chk("burst_done_count", 32'(done_cnt - d0), 32'd1);
    chk("burst_words_left", 32'(exp_q.size()), 32'd0);
    chk("burst_addrs_left", 32'(addr_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    int n;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    out_ready = 1'b1;
    for (int i = 0; i < NW; i++) ram[i] = DW'($urandom);
    for (int i = 0; i < 8; i++) ram[i] = DW'(32'h100 + i);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    flush_model();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Basic 8-word burst with exact cycle timing.
    d0 = done_cnt;
    cmd_addr = '0;
    cmd_len = 11'd8;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      chk("t1_ram_en", 32'(ram_en), 32'(k <= 8));
      chk("t1_out_valid", 32'(out_valid), 32'(k >= 4 && k <= 11));
      chk("t1_done", 32'(done), 32'(k == 12));
      chk("t1_busy", 32'(busy), 32'(k <= 11));
      cycle();
    end
    chk("t1_done_count", 32'(done_cnt - d0), 32'd1);
    chk("t1_words_left", 32'(exp_q.size()), 32'd0);

    // Address wrap at the top of the RAM.
    run_burst(10'h3FE, 11'd4, 0, 60);

    // Backpressure with a long stall in the middle.
    run_burst(10'h050, 11'd16, 1, 300);

    // Zero-length command.
    d0 = done_cnt;
    cmd_addr = 10'h123;
    cmd_len = 11'd0;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_ram_en", 32'(ram_en), 32'd0);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    cycle();
    chk("t4_done_clear", 32'(done), 32'd0);
    chk("t4_busy2", 32'(busy), 32'd0);
    chk("t4_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset in the middle of a burst, then a short recovery burst.
    d0 = done_cnt;
    cmd_addr = 10'h020;
    cmd_len = 11'd8;
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
    chk("t5_ram_en_rise", 32'(ram_en), 32'd1);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    flush_model();
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_ram_en", 32'(ram_en), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (6) cycle();
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    run_burst(10'h030, 11'd2, 0, 40);

    // Back-to-back: second command held during the first burst.
    d0 = done_cnt;
    cmd_addr = 10'h100;
    cmd_len = 11'd6;
    cmd_valid = 1'b1;
    cycle();
    cmd_addr = 10'h200;
    cmd_len = 11'd3;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 60) begin
      cycle();
      n++;
    end
    chk("t6_accept_ready", 32'(cmd_ready), 32'd1);
    chk("t6_accept_on_done", 32'(done), 32'd1);
    cycle();
    chk("t6_second_accepted", 32'(last_acc), 32'd1);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("t6_first_valid", 32'(out_valid), 32'(k == 4));
      cycle();
    end
    n = 0;
    while (done_cnt - d0 < 2 && n < 60) begin
      cycle();
      n++;
    end
    chk("t6_done_count", 32'(done_cnt - d0), 32'd2);
    chk("t6_words_left", 32'(exp_q.size()), 32'd0);

    // Boundary lengths: a single word and the whole RAM.
    run_burst(10'h3FF, 11'd1, 2, 60);
    run_burst(10'h155, 11'd1024, 0, 1200);

    // Random bursts under random backpressure.
    for (int r = 0; r < 8; r++) begin
      run_burst(AW'($urandom_range(0, NW - 1)), (AW+1)'($urandom_range(1, 24)), 2, 600);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
